// File: rtl/div_sequencer.sv
// Divide/remainder sequencer between the pipeline and a multi-cycle divider.
// Divide-by-zero and signed overflow are answered directly. A one-entry cache
// of the last divider result lets a div followed by a rem (or the reverse) on
// the same operands skip the divider.
//
//   state | meaning
//   IDLE  | ready for a new op
//   START | one-cycle start pulse to the divider
//   WAIT  | divider busy, result still wanted
//   RESP  | one-cycle response to the pipeline
//   DRAIN | divider busy, result discarded after a flush
package div_sequencer_pkg;
  typedef logic [2:0] muldiv_funct3_t;
  localparam muldiv_funct3_t FUNCT3_MUL  = 3'd0;
  localparam muldiv_funct3_t FUNCT3_DIV  = 3'd4;
  localparam muldiv_funct3_t FUNCT3_DIVU = 3'd5;
  localparam muldiv_funct3_t FUNCT3_REM  = 3'd6;
  localparam muldiv_funct3_t FUNCT3_REMU = 3'd7;
endpackage

module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int CACHE_EN = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  input  muldiv_funct3_t req_funct3,
  input  logic [31:0]    req_rs1,
  input  logic [31:0]    req_rs2,
  output logic           req_ready,
  input  logic           flush,
  output logic           resp_valid,
  output logic [31:0]    resp_data,
  output logic           div_start,
  output muldiv_funct3_t div_sign,
  output logic [31:0]    div_numerator,
  output logic [31:0]    div_denominator,
  input  logic [31:0]    div_quotient,
  input  logic [31:0]    div_remainder,
  input  logic           div_done
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_RESP, S_DRAIN} state_t;

  state_t         state_q, state_d;
  muldiv_funct3_t op_funct3;
  logic [31:0]    op_rs1, op_rs2, res_q;
  logic           cache_valid, cache_signed;
  logic [31:0]    cache_rs1, cache_rs2, cache_q, cache_r;

  logic        accept, req_signed, div_by_zero, sgn_overflow, special, cache_hit;
  logic [31:0] fast_result;

  assign accept       = req_valid && (state_q == S_IDLE) && req_funct3[2] && !flush;
  assign req_signed   = !req_funct3[0];
  assign div_by_zero  = (req_rs2 == 32'd0);
  assign sgn_overflow = req_signed && (req_rs1 == 32'h8000_0000) && (req_rs2 == 32'hFFFF_FFFF);
  assign special      = div_by_zero || sgn_overflow;
  assign cache_hit    = (CACHE_EN != 0) && cache_valid && (cache_rs1 == req_rs1) &&
                        (cache_rs2 == req_rs2) && (cache_signed == req_signed);

  // Answer for ops that bypass the divider; special cases win over a cache hit.
  always_comb begin
    fast_result = req_funct3[1] ? cache_r : cache_q;
    if (div_by_zero)
      fast_result = req_funct3[1] ? req_rs1 : 32'hFFFF_FFFF;
    else if (sgn_overflow)
      fast_result = req_funct3[1] ? 32'd0 : 32'h8000_0000;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (special || cache_hit) ? S_RESP : S_START;
      S_START: state_d = flush ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (div_done && flush) state_d = S_IDLE;
        else if (div_done)     state_d = S_RESP;
        else if (flush)        state_d = S_DRAIN;
      end
      S_RESP:  state_d = S_IDLE;
      S_DRAIN: if (div_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and divider-control outputs decoded from the state.
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    div_start  = (state_q == S_START);
    resp_valid = (state_q == S_RESP) && !flush;
  end

  assign resp_data       = res_q;
  assign div_sign        = op_funct3;
  assign div_numerator   = op_rs1;
  assign div_denominator = op_rs2;

  // Operand latches, result register and the last-result cache.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_funct3    <= FUNCT3_DIV;
      op_rs1       <= '0;
      op_rs2       <= '0;
      res_q        <= '0;
      cache_valid  <= 1'b0;
      cache_signed <= 1'b0;
      cache_rs1    <= '0;
      cache_rs2    <= '0;
      cache_q      <= '0;
      cache_r      <= '0;
    end else begin
      if (accept) begin
        op_funct3 <= req_funct3;
        op_rs1    <= req_rs1;
        op_rs2    <= req_rs2;
        if (special || cache_hit) res_q <= fast_result;
      end
      // Only a completion that goes on to RESP refreshes the cache.
      if ((state_q == S_WAIT) && div_done && !flush) begin
        res_q        <= op_funct3[1] ? div_remainder : div_quotient;
        cache_valid  <= 1'b1;
        cache_signed <= !op_funct3[0];
        cache_rs1    <= op_rs1;
        cache_rs2    <= op_rs2;
        cache_q      <= div_quotient;
        cache_r      <= div_remainder;
      end
    end
  end

endmodule
